// File: rtl/riscv_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : riscv_data_mem
// Purpose  : Data-memory responder for the riscv core data port. Serves word
//            loads/stores from an on-chip synchronous RAM (one-cycle
//            registered read data) and exposes a small memory-mapped
//            timer/status block with a level interrupt output.
// Ports    : clk     - clock, rising edge
//            rst     - asynchronous reset, active low (0 = reset)
//            ce_i    - request enable
//            we_i    - 1 = store, 0 = load
//            addr_i  - byte address
//            data_i  - store data
//            data_o  - registered load data
//            irq_o   - timer interrupt (STATUS.match & CTRL.irq_en)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_data_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  localparam logic [2:0] OFF_CNT    = 3'd0;
  localparam logic [2:0] OFF_CMP    = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_ERR    = 3'd4;

  // Storage
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cnt;
  logic [31:0] cmp;
  logic [1:0]  ctrl;      // bit0 timer enable, bit1 irq enable
  logic [2:0]  status;    // bit0 match, bit1 err_align, bit2 err_map
  logic [31:0] err_addr;

  // Decode
  logic          misaligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [2:0]    reg_off;
  logic          rd_req;
  logic          wr_req;
  logic          ram_wr;
  logic          reg_wr;
  logic          err_align_set;
  logic          err_map_set;
  logic          match_set;
  logic [2:0]    status_set;
  logic [2:0]    status_clr;
  logic [31:0]   reg_rdata;
  logic [31:0]   load_data;

  assign misaligned = addr_i[1:0] != 2'b00;
  assign ram_hit    = {1'b0, addr_i} < RAM_BYTES;
  assign mmio_hit   = addr_i[31:5] == MMIO_BASE[31:5];
  assign ram_idx    = addr_i[AW+1:2];
  assign reg_off    = addr_i[4:2];

  assign rd_req = ce_i & ~we_i;
  assign wr_req = ce_i &  we_i;

  // Misalignment is checked before the region decode, so a misaligned
  // address is never also reported as unmapped.
  assign err_align_set = ce_i & misaligned;
  assign err_map_set   = ce_i & ~misaligned & ~ram_hit & ~mmio_hit;

  assign ram_wr = wr_req & ~misaligned & ram_hit;
  assign reg_wr = wr_req & ~misaligned & ~ram_hit & mmio_hit;

  // Compare uses the pre-increment count of the current cycle.
  assign match_set  = ctrl[0] & (cnt == cmp);
  assign status_set = {err_map_set, err_align_set, match_set};
  assign status_clr = (reg_wr && reg_off == OFF_STATUS) ? data_i[2:0] : 3'b000;

  // Interrupt is a pure function of registered state.
  assign irq_o = status[0] & ctrl[1];

  always_comb begin
    reg_rdata = 32'h0;
    case (reg_off)
      OFF_CNT:    reg_rdata = cnt;
      OFF_CMP:    reg_rdata = cmp;
      OFF_CTRL:   reg_rdata = {30'h0, ctrl};
      OFF_STATUS: reg_rdata = {29'h0, status};
      OFF_ERR:    reg_rdata = err_addr;
      default:    reg_rdata = 32'h0;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    if (!misaligned) begin
      if (ram_hit) begin
        load_data = mem[ram_idx];
      end else if (mmio_hit) begin
        load_data = reg_rdata;
      end
    end
  end

  // RAM array carries no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_idx] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o   <= 32'h0;
      cnt      <= 32'h0;
      cmp      <= 32'hFFFF_FFFF;
      ctrl     <= 2'b00;
      status   <= 3'b000;
      err_addr <= 32'h0;
    end else begin
      if (rd_req) begin
        data_o <= load_data;
      end

      // Software write wins over the free-running increment.
      if (reg_wr && reg_off == OFF_CNT) begin
        cnt <= data_i;
      end else if (ctrl[0]) begin
        cnt <= cnt + 32'd1;
      end

      if (reg_wr && reg_off == OFF_CMP) begin
        cmp <= data_i;
      end

      if (reg_wr && reg_off == OFF_CTRL) begin
        ctrl <= data_i[1:0];
      end

      // Hardware set is OR-ed after the clear so it wins a same-cycle W1C.
      status <= (status & ~status_clr) | status_set;

      // Capture only the first error: both error flags must be clear.
      if ((err_align_set || err_map_set) && status[2:1] == 2'b00) begin
        err_addr <= addr_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_data_mem
// Purpose  : Self-checking bench for riscv_data_mem. Table of load/store
//            vectors plus hand-written timer, wrap, collision and reset
//            sequences; load results are checked through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_data_mem;

  localparam logic [31:0] MB      = 32'hFFFF_0000;
  localparam logic [31:0] A_CNT   = MB + 32'h00;
  localparam logic [31:0] A_CMP   = MB + 32'h04;
  localparam logic [31:0] A_CTRL  = MB + 32'h08;
  localparam logic [31:0] A_STAT  = MB + 32'h0C;
  localparam logic [31:0] A_ERR   = MB + 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;

  riscv_data_mem #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE  (MB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce_i  (ce_i),
    .we_i  (we_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .data_o(data_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;   // store data, or expected load data
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: a load sampled at this edge is checked just after it.
  logic mon_pend;
  exp_t mon_e;
  always @(posedge clk) begin
    mon_pend = ce_i & ~we_i & rst;
    #1;
    if (mon_pend) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got load with data %h, expected none", data_o);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, data_o, mon_e.exp);
      end
    end
  end

  task automatic drive(input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce_i   = ce;
    we_i   = we;
    addr_i = a;
    data_i = d;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    drive(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d, input string name);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Vector table: RAM round trip, errors, register map corners.
    add(1, 32'h10,       32'hDEAD_BEEF, "st10");
    add(0, 32'h10,       32'hDEAD_BEEF, "ld10");
    add(1, 32'h0,        32'h1111_1111, "st0");
    add(1, 32'h4,        32'h2222_2222, "st4");
    add(0, 32'h0,        32'h1111_1111, "ld0");
    add(0, 32'h4,        32'h2222_2222, "ld4");
    add(1, 32'h13,       32'hAAAA_AAAA, "st13_misaligned");
    add(0, 32'h10,       32'hDEAD_BEEF, "ram_unchanged");
    add(0, A_STAT,       32'h2,         "status_align");
    add(0, A_ERR,        32'h13,        "erraddr_13");
    add(0, 32'h8000_0000,32'h0,         "ld_unmapped");
    add(0, A_STAT,       32'h6,         "status_both");
    add(0, A_ERR,        32'h13,        "erraddr_first");
    add(1, A_STAT,       32'h6,         "w1c");
    add(0, A_STAT,       32'h0,         "status_clear");
    add(1, A_ERR,        32'h1234_5678, "st_err_ro");
    add(0, A_ERR,        32'h13,        "erraddr_ro");
    add(1, MB + 32'h14,  32'h5555_5555, "st_reserved");
    add(0, MB + 32'h14,  32'h0,         "ld_reserved");
    add(0, A_STAT,       32'h0,         "reserved_no_err");
    add(1, 32'hFFC,      32'hCAFE_F00D, "st_lastword");
    add(0, 32'hFFC,      32'hCAFE_F00D, "ld_lastword");
    add(1, 32'h1000,     32'h7777_7777, "st_just_past_ram");
    add(0, A_STAT,       32'h4,         "status_map");
    add(0, A_ERR,        32'h1000,      "erraddr_1000");
    add(1, A_STAT,       32'h7,         "w1c_all");
    add(1, A_CTRL,       32'hFFFF_FFF6, "st_ctrl");
    add(0, A_CTRL,       32'h2,         "ctrl_masked");
    add(1, A_CTRL,       32'h0,         "ctrl_off");
    add(1, A_CMP,        32'h5,         "st_cmp");
    add(0, A_CMP,        32'h5,         "ld_cmp");
    add(0, A_CNT,        32'h0,         "cnt_idle");

    rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_o, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    load(A_CMP,  32'hFFFF_FFFF, "rst_cmp");
    load(A_CTRL, 32'h0,         "rst_ctrl");
    load(A_STAT, 32'h0,         "rst_status");
    load(A_ERR,  32'h0,         "rst_err");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) store(tbl[i].addr, tbl[i].data);
      else           load(tbl[i].addr, tbl[i].data, tbl[i].name);
    end

    // Hold: idle cycles and a store leave data_o unchanged.
    load(32'h10, 32'hDEAD_BEEF, "ld_hold");
    idle(3);
    #1 check("hold_idle", data_o, 32'hDEAD_BEEF);
    store(32'h20, 32'h0000_0055);
    #1 check("hold_store", data_o, 32'hDEAD_BEEF);

    // Timer match: CNT=0, CMP=5. Enabled after edge E0; match at E6.
    store(A_CTRL, 32'h3);
    idle(5);
    #1 check("irq_before_match", {31'h0, irq_o}, 32'h0);
    idle(1);
    #1 check("irq_at_match", {31'h0, irq_o}, 32'h1);
    load(A_CNT, 32'h6, "cnt_at_irq");
    store(A_STAT, 32'h1);
    #1 check("irq_w1c", {31'h0, irq_o}, 32'h0);
    store(A_CTRL, 32'h0);

    // Wrap.
    store(A_CNT, 32'hFFFF_FFFE);
    store(A_CTRL, 32'h1);
    idle(1);
    load(A_CNT, 32'hFFFF_FFFF, "cnt_max");
    load(A_CNT, 32'h0,         "cnt_wrap");

    // Write beats increment.
    store(A_CNT, 32'h100);
    load(A_CNT, 32'h100, "cnt_write_wins");

    // Running timer with irq high, then asynchronous reset.
    store(A_CTRL, 32'h3);
    store(A_CMP,  32'h200);
    store(A_CNT,  32'h1F0);
    for (int i = 0; i < 40 && !irq_o; i++) idle(1);
    #1 check("irq_before_reset", {31'h0, irq_o}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_data", data_o, 32'h0);
    check("async_rst_irq", {31'h0, irq_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    load(A_CNT,  32'h0,         "post_rst_cnt");
    load(A_CMP,  32'hFFFF_FFFF, "post_rst_cmp");
    load(A_CTRL, 32'h0,         "post_rst_ctrl");
    load(A_STAT, 32'h0,         "post_rst_status");
    load(A_ERR,  32'h0,         "post_rst_err");
    load(32'h10, 32'hDEAD_BEEF, "post_rst_ram10");
    load(32'h0,  32'h1111_1111, "post_rst_ram0");
    idle(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
